// File: rtl/abro_channel_arbiter.sv
// Multi-channel ABRO controller with a shared, round-robin scheduled event
// output. Each channel waits for A and B (any order), raises one event, then
// stays silent until its restart R. Events leave through one registered
// valid/ready port; accepted handshakes are counted.
module abro_channel_arbiter #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(2**CH_W)-1:0]  a,
  input  logic [(2**CH_W)-1:0]  b,
  input  logic [(2**CH_W)-1:0]  r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [(2**CH_W)-1:0]  done,
  output logic [CNT_W-1:0]      evt_cnt
);

  localparam int NCH = 2**CH_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GOT_A = 3'd1;
  localparam logic [2:0] ST_GOT_B = 3'd2;
  localparam logic [2:0] ST_PEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]      ch_state [NCH];
  logic [CH_W-1:0] last_grant;
  logic [NCH-1:0]  cand_mask;
  logic            grant_vld;
  logic [CH_W-1:0] grant_idx;
  logic            out_free;
  logic            load;

  // Candidates: pending channels not being restarted this cycle (r wins).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    cand_mask = '0;
    done      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_mask[i] = (ch_state[i] == ST_PEND) && !r[i];
      done[i]      = (ch_state[i] == ST_DONE);
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [CH_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = last_grant + CH_W'(off);
      if (!grant_vld && cand_mask[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The output register may take a new event when empty or being drained.
  assign out_free = !out_valid || out_ready;
  assign load     = out_free && grant_vld;

  // Per-channel ABRO state machines; restart has priority over a and b.
  always_ff @(posedge clk) begin
    // NOTE: the channel state array is a handful of flops, not a RAM, so it is
    // reset explicitly; every channel must start in IDLE.
    if (reset) begin
      for (int i = 0; i < NCH; i++) ch_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r[i]) begin
          ch_state[i] <= ST_IDLE;
        end else begin
          case (ch_state[i])
            ST_IDLE: begin
              if (a[i] && b[i]) ch_state[i] <= ST_PEND;
              else if (a[i])    ch_state[i] <= ST_GOT_A;
              else if (b[i])    ch_state[i] <= ST_GOT_B;
            end
            ST_GOT_A: if (b[i]) ch_state[i] <= ST_PEND;
            ST_GOT_B: if (a[i]) ch_state[i] <= ST_PEND;
            ST_PEND:  if (load && (grant_idx == CH_W'(i))) ch_state[i] <= ST_DONE;
            ST_DONE:  ch_state[i] <= ST_DONE;
            default:  ch_state[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Output register and grant pointer; a loaded event is never retracted.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      last_grant <= CH_W'(NCH - 1);
    end else if (out_free) begin
      if (grant_vld) begin
        out_valid  <= 1'b1;
        out_ch     <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

  // Accepted-handshake counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_cnt <= '0;
    end else if (out_valid && out_ready) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_abro_channel_arbiter.sv
// Directed bench for abro_channel_arbiter: a vector table for the basic
// sequences plus hand-written multi-cycle corner cases.
module tb_abro_channel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a, b, r;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_ch;
  logic [3:0] done;
  logic [7:0] evt_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] a, b, r;
    logic       rdy;
    logic       ev;
    logic [1:0] ech;
    logic [3:0] edone;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  abro_channel_arbiter #(.CH_W(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .r(r),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .done(done), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [3:0] va, logic [3:0] vb,
                              logic [3:0] vr, logic rdy, logic ev,
                              logic [1:0] ech, logic [3:0] edone,
                              logic [7:0] ecnt);
    vec_t v;
    v.rst = rst; v.a = va; v.b = vb; v.r = vr; v.rdy = rdy;
    v.ev = ev; v.ech = ech; v.edone = edone; v.ecnt = ecnt;
    return v;
  endfunction

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic rst, input logic [3:0] va, input logic [3:0] vb,
                     input logic [3:0] vr, input logic rdy);
    @(negedge clk);
    reset = rst; a = va; b = vb; r = vr; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [1:0] ech,
                       input logic [3:0] edone, input logic [7:0] ecnt);
    checks++;
    if (out_valid !== ev || out_ch !== ech || done !== edone || evt_cnt !== ecnt) begin
      errors++;
      $display("FAIL %s: got valid=%0b ch=%0d done=%b cnt=%0d, need valid=%0b ch=%0d done=%b cnt=%0d",
               name, out_valid, out_ch, done, evt_cnt, ev, ech, edone, ecnt);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    reset = 1'b1; a = '0; b = '0; r = '0; out_ready = 1'b1;

    //                rst a       b       r       rdy  ev ch  done    cnt
    // reset
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0));
    // basic ABRO on channel 0
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 4'b0000, 1));
    // simultaneous a&b on channel 2, then restart with a&b, then fresh a, b
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2, 4'b0100, 2));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 2, 4'b0000, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2, 4'b0000, 2));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 2, 4'b0000, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0100, 4'b0000, 1, 0, 2, 4'b0000, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2, 4'b0100, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2, 4'b0100, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0100, 1, 0, 2, 4'b0000, 3));
    // round robin from reset: order 0,1,2,3 with no bubbles
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0011, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2, 4'b0111, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 3, 4'b1111, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 3, 4'b1111, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 1, 0, 3, 4'b0000, 4));
    // single event on channel 1 leaves last_grant=1
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 0, 3, 4'b0000, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0010, 4));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 4'b0010, 5));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0010, 1, 0, 1, 4'b0000, 5));
    // round robin from last_grant=1: order 2,3,0,1
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 1, 0, 1, 4'b0000, 5));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2, 4'b0100, 5));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 3, 4'b1100, 6));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 4'b1101, 7));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b1111, 8));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 4'b1111, 9));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 1, 0, 1, 4'b0000, 9));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ech, vecs[i].edone, vecs[i].ecnt);
    end

    // Backpressure: channels 1 and 3 pending, consumer stalled.
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 0);
    check("bp_reset", 0, 0, 4'b0000, 0);
    cyc(0, 4'b1010, 4'b1010, 4'b0000, 0);
    check("bp_pend", 0, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 0);
      check($sformatf("bp_stall%0d", i), 1, 1, 4'b0010, 0);
    end
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("bp_drain1", 1, 3, 4'b1010, 1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("bp_drain3", 0, 3, 4'b1010, 2);
    cyc(0, 4'b0000, 4'b0000, 4'b1010, 1);
    check("bp_restart", 0, 3, 4'b0000, 2);

    // Restart race: r[1] in the selecting cycle hands the slot to channel 3.
    cyc(0, 4'b1010, 4'b1010, 4'b0000, 1);
    check("race_pend", 0, 3, 4'b0000, 2);
    cyc(0, 4'b0000, 4'b0000, 4'b0010, 1);
    check("race_sel3", 1, 3, 4'b1000, 2);
    // channel 1 must be back in IDLE: b alone only gets it to GOT_B
    cyc(0, 4'b0000, 4'b0010, 4'b0000, 1);
    check("race_idle", 0, 3, 4'b1000, 3);
    cyc(0, 4'b0010, 4'b0000, 4'b1000, 1);
    check("race_gotb", 0, 3, 4'b0000, 3);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("race_emit1", 1, 1, 4'b0010, 3);
    // r on a loaded channel does not retract the event
    cyc(0, 4'b0000, 4'b0000, 4'b0010, 0);
    check("loaded_r", 1, 1, 4'b0000, 3);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("loaded_acc", 0, 1, 4'b0000, 4);

    // Counter wrap: run channel 0 repeatedly until evt_cnt reaches 255.
    exp_cnt = 8'd4;
    for (int i = 0; i < 251; i++) begin
      cyc(0, 4'b0001, 4'b0001, 4'b0000, 1);
      cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
      cyc(0, 4'b0000, 4'b0000, 4'b0001, 1);
      exp_cnt = exp_cnt + 8'd1;
    end
    check("cnt_255", 0, 0, 4'b0000, exp_cnt);
    cyc(0, 4'b0001, 4'b0001, 4'b0000, 1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("wrap_load", 1, 0, 4'b0001, 8'd255);
    cyc(0, 4'b0000, 4'b0000, 4'b0001, 1);
    check("cnt_wrap", 0, 0, 4'b0000, 8'd0);

    // Reset while an event is stalled: event dropped and not counted.
    cyc(0, 4'b0100, 4'b0100, 4'b0000, 0);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 0);
    check("rst_pre", 1, 2, 4'b0100, 0);
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 0);
    check("rst_mid", 0, 0, 4'b0000, 0);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("rst_lost", 0, 0, 4'b0000, 0);
    // last_grant back to 3: channel 0 wins over channel 1
    cyc(0, 4'b0011, 4'b0011, 4'b0000, 1);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 1);
    check("rst_grant", 1, 0, 4'b0001, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
